// File: rtl/pulse_desc_dispatcher.sv
// -----------------------------------------------------------------------------
// pulse_desc_dispatcher
//
// Consumes pulse descriptors {chan, amp, start, dur} from the read port of the
// pulse-instruction FIFO. Each descriptor waits in a one-entry pending slot
// until the local timebase reaches its start time. It then moves to the active
// slot, which drives a channel/amplitude pulse for dur cycles of run=1. Pending
// refills while a pulse plays, so back-to-back pulses hand off with no gap.
//
// Ports
//   clk, rst_n    ps-domain clock, asynchronous active-low reset
//   run           level: timebase counts and dispatch enabled
//   tb_clear      1-cycle pulse: timebase to 0, late_err cleared
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO pop request (data valid the following cycle)
//   fifo_rd_data  {chan, amp, start, dur}, MSB..LSB
//   pulse_valid   pulse driven this cycle (registered)
//   pulse_chan    channel of the active pulse, 0 when idle
//   pulse_amp     amplitude of the active pulse, 0 when idle
//   t_now         local timebase
//   pulse_count   pulses completed since reset (wraps)
//   late_err      sticky: a pulse started after its start time
//   busy          pending or active descriptor held, or a pop in flight
// -----------------------------------------------------------------------------
module pulse_desc_dispatcher #(
  parameter int CW = 2,
  parameter int AW = 16,
  parameter int TW = 32,
  parameter int DW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   tb_clear,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [CW+AW+TW+DW-1:0] fifo_rd_data,
  output logic                   pulse_valid,
  output logic [CW-1:0]          pulse_chan,
  output logic [AW-1:0]          pulse_amp,
  output logic [TW-1:0]          t_now,
  output logic [15:0]            pulse_count,
  output logic                   late_err,
  output logic                   busy
);

  typedef enum logic {IDLE, PLAY} state_e;

  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [DW-1:0] DUR_ONE = DW'(1);

  // Descriptor fields as presented by the FIFO
  logic [CW-1:0] in_chan;
  logic [AW-1:0] in_amp;
  logic [TW-1:0] in_start;
  logic [DW-1:0] in_dur;
  assign {in_chan, in_amp, in_start, in_dur} = fifo_rd_data;

  logic [TW-1:0] t_now_q, t_now_d;
  logic          pop_inflight_q;
  logic          pend_full_q;
  logic [CW-1:0] pend_chan_q;
  logic [AW-1:0] pend_amp_q;
  logic [TW-1:0] pend_start_q;
  logic [DW-1:0] pend_dur_q;
  state_e        state_q;
  logic [DW-1:0] dur_cnt_q;
  logic          pulse_valid_q;
  logic [CW-1:0] pulse_chan_q;
  logic [AW-1:0] pulse_amp_q;
  logic [15:0]   pulse_count_q;
  logic          late_err_q;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    t_now_d = t_now_q;
    if (tb_clear)  t_now_d = '0;
    else if (run)  t_now_d = t_now_q + T_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t_now_q <= '0;
    else        t_now_q <= t_now_d;
  end

  // Due/late are judged against the timebase value of the pulse's first driven
  // cycle: pulse outputs are registered, so the transfer happens one edge ahead
  // and the pulse becomes visible exactly when t_now == start.
  logic [TW-1:0] due_diff;
  logic          pend_due;
  logic          last_cycle;
  logic          take_pend;

  assign due_diff   = t_now_d - pend_start_q;
  assign pend_due   = !due_diff[TW-1];
  assign last_cycle = (state_q == PLAY) && run && (dur_cnt_q == DUR_ONE);
  assign take_pend  = run && pend_full_q && pend_due &&
                      ((state_q == IDLE) || last_cycle);

  // Reset is folded in so no pop can be requested while held in reset.
  assign fifo_rd_en = rst_n && !fifo_empty && !pend_full_q && !pop_inflight_q;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_inflight_q <= 1'b0;
      pend_full_q    <= 1'b0;
    end else begin
      pop_inflight_q <= fifo_rd_en;
      // Pending is always empty while a pop is in flight, so capture and
      // transfer never coincide. Zero-duration descriptors are dropped here.
      if (pop_inflight_q)  pend_full_q <= (in_dur != '0);
      else if (take_pend)  pend_full_q <= 1'b0;
    end
  end

  // NOTE: the pending payload is left out of reset; pend_full_q qualifies it,
  // so its contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (pop_inflight_q) begin
      pend_chan_q  <= in_chan;
      pend_amp_q   <= in_amp;
      pend_start_q <= in_start;
      pend_dur_q   <= in_dur;
    end
  end

  // Active slot FSM with registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dur_cnt_q     <= '0;
      pulse_valid_q <= 1'b0;
      pulse_chan_q  <= '0;
      pulse_amp_q   <= '0;
      pulse_count_q <= '0;
      late_err_q    <= 1'b0;
    end else begin
      if (tb_clear) late_err_q <= 1'b0;

      if (take_pend) begin
        // Covers both IDLE->PLAY and the gapless PLAY->PLAY handoff
        state_q       <= PLAY;
        dur_cnt_q     <= pend_dur_q;
        pulse_valid_q <= 1'b1;
        pulse_chan_q  <= pend_chan_q;
        pulse_amp_q   <= pend_amp_q;
        // A late start in the clear cycle is a new event and stays flagged
        if (t_now_d != pend_start_q) late_err_q <= 1'b1;
      end else if (last_cycle) begin
        state_q       <= IDLE;
        dur_cnt_q     <= '0;
        pulse_valid_q <= 1'b0;
        pulse_chan_q  <= '0;
        pulse_amp_q   <= '0;
      end else if ((state_q == PLAY) && run) begin
        dur_cnt_q <= dur_cnt_q - DUR_ONE;
      end

      if (last_cycle) pulse_count_q <= pulse_count_q + 16'd1;
    end
  end

  assign pulse_valid = pulse_valid_q;
  assign pulse_chan  = pulse_chan_q;
  assign pulse_amp   = pulse_amp_q;
  assign t_now       = t_now_q;
  assign pulse_count = pulse_count_q;
  assign late_err    = late_err_q;
  assign busy        = pend_full_q || pop_inflight_q || (state_q == PLAY);

endmodule

// File: tb/tb_pulse_desc_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_desc_dispatcher
//
// Directed bench with a scoreboard. Each test pushes descriptors into a small
// FIFO model and queues the pulse it should produce (channel, amplitude, t_now
// on the first driven cycle, driven length in cycles, late_err at completion).
// A monitor segments the DUT output into pulses using pulse_count steps and
// compares each completed pulse against the queue head.
// -----------------------------------------------------------------------------
module tb_pulse_desc_dispatcher;

  localparam int CW = 2;
  localparam int AW = 16;
  localparam int TW = 32;
  localparam int DW = 16;
  localparam int DESC_W = CW + AW + TW + DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              tb_clear;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DESC_W-1:0] fifo_rd_data = '0;
  logic              pulse_valid;
  logic [CW-1:0]     pulse_chan;
  logic [AW-1:0]     pulse_amp;
  logic [TW-1:0]     t_now;
  logic [15:0]       pulse_count;
  logic              late_err;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pulse_desc_dispatcher #(.CW(CW), .AW(AW), .TW(TW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .tb_clear     (tb_clear),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .pulse_valid  (pulse_valid),
    .pulse_chan   (pulse_chan),
    .pulse_amp    (pulse_amp),
    .t_now        (t_now),
    .pulse_count  (pulse_count),
    .late_err     (late_err),
    .busy         (busy)
  );

  // FIFO model: written only by the stimulus process, popped only here.
  logic [DESC_W-1:0] mem [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic force_empty = 1'b0;

  assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [CW-1:0] chan;
    logic [AW-1:0] amp;
    logic [TW-1:0] t0;
    int            len;
    logic          late;
  } exp_t;

  exp_t exp_q[$];
  int   valid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_desc(input logic [CW-1:0] chan, input logic [AW-1:0] amp,
                           input logic [TW-1:0] start, input logic [DW-1:0] dur);
    mem[wr_ptr[5:0]] = {chan, amp, start, dur};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_pulse(input logic [CW-1:0] chan, input logic [AW-1:0] amp,
                              input logic [TW-1:0] t0, input int len,
                              input logic late);
    exp_t e;
    e.chan = chan; e.amp = amp; e.t0 = t0; e.len = len; e.late = late;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n       = 1'b0;
    run         = 1'b0;
    tb_clear    = 1'b0;
    force_empty = 1'b0;
  endtask

  task automatic release_dut();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_t(input logic [TW-1:0] val, input int budget);
    int n = 0;
    while ((t_now != val) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("wait_t_now", t_now, val);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (((exp_q.size() != 0) || busy) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_pulses", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    logic [15:0]   last_cnt = '0;
    int            seg_len  = 0;
    logic          seg_bad  = 1'b0;
    logic [CW-1:0] seg_chan = '0;
    logic [AW-1:0] seg_amp  = '0;
    logic [TW-1:0] seg_t0   = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_cnt = '0;
        seg_len  = 0;
        seg_bad  = 1'b0;
      end else begin
        if (fifo_empty) check("rd_en_while_empty", fifo_rd_en, 0);
        if (pulse_count != last_cnt) begin
          check("count_step", pulse_count, last_cnt + 16'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse_len", seg_len, 0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_chan", seg_chan, e.chan);
            check("pulse_amp", seg_amp, e.amp);
            check("pulse_t0", seg_t0, e.t0);
            check("pulse_len", seg_len, e.len);
            check("pulse_late", late_err, e.late);
            check("pulse_stable", seg_bad, 0);
          end
          last_cnt = pulse_count;
          seg_len  = 0;
          seg_bad  = 1'b0;
        end
        if (pulse_valid) begin
          if (seg_len == 0) begin
            seg_chan = pulse_chan;
            seg_amp  = pulse_amp;
            seg_t0   = t_now;
          end else if ((pulse_chan != seg_chan) || (pulse_amp != seg_amp)) begin
            seg_bad = 1'b1;
          end
          seg_len++;
          valid_cycles++;
        end else begin
          check("idle_chan_amp_zero", {pulse_chan, pulse_amp}, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks",
             n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int v0;
    rst_n    = 1'b0;
    run      = 1'b0;
    tb_clear = 1'b0;

    // Reset state, with a descriptor already waiting in the FIFO
    push_desc(2'd2, 16'h1234, 32'd10, 16'd4);
    #3;
    check("rst_pulse_valid", pulse_valid, 0);
    check("rst_chan_amp", {pulse_chan, pulse_amp}, 0);
    check("rst_t_now", t_now, 0);
    check("rst_count", pulse_count, 0);
    check("rst_late", late_err, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);

    // 1: single on-time pulse, visible for t_now = 10..13
    expect_pulse(2'd2, 16'h1234, 32'd10, 4, 1'b0);
    run = 1'b1;
    release_dut();
    wait_drain(200);
    check("t1_count", pulse_count, 1);
    check("t1_late", late_err, 0);

    // 2: back-to-back pulses, contiguous 10..14 then 15..17
    reset_dut();
    push_desc(2'd1, 16'hAAAA, 32'd10, 16'd5);
    push_desc(2'd3, 16'h5555, 32'd15, 16'd3);
    expect_pulse(2'd1, 16'hAAAA, 32'd10, 5, 1'b0);
    expect_pulse(2'd3, 16'h5555, 32'd15, 3, 1'b0);
    run = 1'b1;
    release_dut();
    wait_drain(200);
    check("t2_count", pulse_count, 2);
    check("t2_late", late_err, 0);

    // 3: prefetch while stopped, late start on resume, then tb_clear
    reset_dut();
    push_desc(2'd1, 16'h1111, 32'd3, 16'd4);
    expect_pulse(2'd1, 16'h1111, 32'd3, 4, 1'b0);
    release_dut();
    repeat (5) @(negedge clk);
    check("t3_hold_t_now", t_now, 0);
    check("t3_pending_busy", busy, 1);
    run = 1'b1;
    wait_t(32'd20, 100);
    run = 1'b0;
    push_desc(2'd2, 16'h2222, 32'd5, 16'd2);
    expect_pulse(2'd2, 16'h2222, 32'd21, 2, 1'b1);
    repeat (6) @(negedge clk);
    check("t3_no_start_stopped", pulse_valid, 0);
    check("t3_frozen_t_now", t_now, 20);
    run = 1'b1;
    wait_drain(100);
    check("t3_count", pulse_count, 2);
    check("t3_late", late_err, 1);
    tb_clear = 1'b1;
    @(negedge clk);
    tb_clear = 1'b0;
    check("t3_clear_t_now", t_now, 0);
    check("t3_clear_late", late_err, 0);

    // 4: FIFO held empty, then a zero-duration descriptor
    reset_dut();
    force_empty = 1'b1;
    push_desc(2'd1, 16'h7777, 32'd30, 16'd0);
    run = 1'b1;
    release_dut();
    repeat (20) @(negedge clk);
    check("t4_busy_empty", busy, 0);
    check("t4_valid_empty", pulse_valid, 0);
    check("t4_not_popped", wr_ptr - rd_ptr, 1);
    v0 = valid_cycles;
    force_empty = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_popped", wr_ptr - rd_ptr, 0);
    check("t4_count", pulse_count, 0);
    check("t4_busy", busy, 0);
    check("t4_never_driven", valid_cycles - v0, 0);

    // 5: run dropped for 3 cycles mid-pulse stretches dur=8 to 11 cycles
    reset_dut();
    push_desc(2'd0, 16'h0F0F, 32'd12, 16'd8);
    expect_pulse(2'd0, 16'h0F0F, 32'd12, 11, 1'b0);
    run = 1'b1;
    release_dut();
    wait_t(32'd14, 100);
    run = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    wait_drain(200);
    check("t5_count", pulse_count, 1);

    // 6: asynchronous reset mid-pulse, then a fresh descriptor from t_now=0
    reset_dut();
    push_desc(2'd3, 16'hBEEF, 32'd5, 16'd10);
    run = 1'b1;
    release_dut();
    wait_t(32'd8, 100);
    check("t6_playing", pulse_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", pulse_valid, 0);
    check("t6_async_chan_amp", {pulse_chan, pulse_amp}, 0);
    check("t6_async_t_now", t_now, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_count", pulse_count, 0);
    push_desc(2'd2, 16'h0ABC, 32'd6, 16'd3);
    expect_pulse(2'd2, 16'h0ABC, 32'd6, 3, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_drain(200);
    check("t6_count", pulse_count, 1);
    check("t6_late", late_err, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
